// File: rtl/slow_timer.sv
`default_nettype none
// ============================================================================
// Module      : slow_timer
// Description : Decides when the CPU must drop to stock speed.
//               A bus cycle to any device whose slow enable is set puts
//               the block in ACTIVE. When the cycle ends, the block moves
//               to HOLD and stays slow for a programmable number of
//               64-cycle prescaler ticks. A new qualifying access during
//               HOLD retriggers the block back to ACTIVE.
//
//               Optional feature macro: SLOW_CLOCKGATE_EN
//                 defined   -> ClockGate is a registered copy of
//                              Slow && SlowClockGate
//                 undefined -> ClockGate is tied to 0
//
// Ports       : CLK            sole clock, rising edge
//               nPOR           asynchronous active-low reset
//               BACT           bus cycle active
//               IACKCS..SndCS  device selects for the current bus cycle
//               SlowIACK..SlowSnd  per-device slow enables
//               SlowClockGate  request to gate the fast clock while slow
//               SlowTimeout    hold time after the cycle, in 64-cycle ticks
//               Slow           CPU must run at stock speed (registered)
//               ClockGate      gate the accelerated clock (registered)
//               SlowState      registered state, for debug
// Revision    : 1.0 - initial release
// ============================================================================
module slow_timer (
  input  logic       CLK,
  input  logic       nPOR,
  input  logic       BACT,
  input  logic       IACKCS,
  input  logic       VIACS,
  input  logic       IWMCS,
  input  logic       SCCCS,
  input  logic       SCSICS,
  input  logic       SndCS,
  input  logic       SlowIACK,
  input  logic       SlowVIA,
  input  logic       SlowIWM,
  input  logic       SlowSCC,
  input  logic       SlowSCSI,
  input  logic       SlowSnd,
  input  logic       SlowClockGate,
  input  logic [3:0] SlowTimeout,
  output logic       Slow,
  output logic       ClockGate,
  output logic [1:0] SlowState
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic [3:0] r_count;
  logic [3:0] w_nextCount;
  logic [5:0] r_presc;
  logic [5:0] w_nextPresc;
  logic       r_slow;
  logic       w_qa;
  logic       w_tick;

  assign w_qa = BACT & ((IACKCS & SlowIACK) | (VIACS  & SlowVIA)  |
                        (IWMCS  & SlowIWM)  | (SCCCS  & SlowSCC)  |
                        (SCSICS & SlowSCSI) | (SndCS  & SlowSnd));

  assign w_tick = (r_presc == 6'd63);

  always_comb begin
    w_nextState = ST_IDLE;
    w_nextCount = r_count;
    w_nextPresc = r_presc;
    case (r_state)
      ST_IDLE: begin
        w_nextState = w_qa ? ST_ACTIVE : ST_IDLE;
      end
      ST_ACTIVE: begin
        if (BACT) begin
          w_nextState = ST_ACTIVE;
        end else begin
          w_nextState = ST_HOLD;
          w_nextCount = SlowTimeout;
          // A zero timeout must leave HOLD after a single cycle, so the
          // prescaler is preset to its terminal value to make the very
          // first HOLD cycle a tick with the counter already at 0.
          w_nextPresc = (SlowTimeout == 4'd0) ? 6'd63 : 6'd0;
        end
      end
      ST_HOLD: begin
        if (w_qa) begin
          // Retrigger: counter and prescaler stay frozen and are
          // reloaded when the new cycle ends.
          w_nextState = ST_ACTIVE;
        end else begin
          w_nextState = ST_HOLD;
          w_nextPresc = r_presc + 6'd1;
          if (w_tick) begin
            if (r_count == 4'd0) begin
              w_nextState = ST_IDLE;
            end else begin
              w_nextCount = r_count - 4'd1;
            end
          end
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      r_state <= ST_IDLE;
      r_count <= 4'd0;
      r_presc <= 6'd0;
      r_slow  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_count <= w_nextCount;
      r_presc <= w_nextPresc;
      // Decoded from the next state so Slow is a clean flop output that
      // changes on the same edge as the state register.
      r_slow  <= (w_nextState != ST_IDLE);
    end
  end

`ifdef SLOW_CLOCKGATE_EN
  logic r_clockGate;

  always_ff @(posedge CLK or negedge nPOR) begin
    if (!nPOR) begin
      r_clockGate <= 1'b0;
    end else begin
      r_clockGate <= (w_nextState != ST_IDLE) & SlowClockGate;
    end
  end

  assign ClockGate = r_clockGate;
`else
  assign ClockGate = 1'b0;
`endif

  assign Slow      = r_slow;
  assign SlowState = r_state;

endmodule
`default_nettype wire

// File: doc/slow_timer.md
SLOW_TIMER -- requirements
Module: slow_timer

Interface
REQ-001 CLK  input  1  sole clock; all state updates on rising edge.
REQ-002 nPOR  input  1  reset, asynchronous assert, active-low.
REQ-003 BACT  input  1  bus cycle active, synchronous to CLK.
REQ-004 IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS  input  1 each  device selects for the current bus cycle.
REQ-005 SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd  input  1 each  per-device slow enables from the settings register.
REQ-006 SlowClockGate  input  1  settings bit requesting that the fast clock be gated while slow.
REQ-007 SlowTimeout  input  4  hold time after the cycle ends, in prescaler ticks.
REQ-008 Slow  output  1  CPU must run at stock speed.
REQ-009 ClockGate  output  1  gate the accelerated clock.
REQ-010 SlowState  output  2  current state encoding, for debug.

Function
REQ-011 Qualifying access (QA) SHALL be BACT && OR over each device select ANDed with its enable; evaluated combinationally each cycle.
REQ-012 States SHALL be IDLE=0, ACTIVE=1, HOLD=2; encoding 3 is illegal and SHALL transition to IDLE on the next edge.
REQ-013 IDLE: on QA, go to ACTIVE on the next edge; Slow=1 from that edge (one-cycle latency).
REQ-014 ACTIVE: remain while BACT=1; when BACT=0, go to HOLD, load the 4-bit counter with SlowTimeout, and clear the prescaler.
REQ-015 HOLD: the 6-bit prescaler increments every CLK; tick = prescaler==63; the counter decrements on each tick.
REQ-016 HOLD exits to IDLE on the edge after the counter is 0 and a tick occurs; Slow=0 from that edge.
REQ-017 SlowTimeout=0 at ACTIVE->HOLD: go to IDLE on the next edge (HOLD lasts exactly 1 cycle).
REQ-018 QA during HOLD: go to ACTIVE on the next edge; counter and prescaler are frozen and reloaded at the next ACTIVE exit (retrigger).
REQ-019 A non-qualifying BACT during HOLD SHALL NOT affect the countdown.
REQ-020 Slow SHALL be 1 in ACTIVE and HOLD and 0 in IDLE; registered, glitch-free.
REQ-021 SlowTimeout is sampled only at the ACTIVE->HOLD transition; later changes do not affect the current countdown.
REQ-022 Counter SHALL never wrap: no decrement at 0.
REQ-023 SlowState SHALL reflect the registered state.

Reset
REQ-024 nPOR=0 SHALL asynchronously force state=IDLE, counter=0, prescaler=0, Slow=0, ClockGate=0.
REQ-025 Reset asserted mid-ACTIVE or mid-HOLD SHALL abandon the operation with no residual Slow after release.
REQ-026 The first QA evaluation SHALL occur on the first rising edge after nPOR deasserts.

Configuration
REQ-027 Macro SLOW_CLOCKGATE_EN defined: ClockGate is registered and equals Slow && SlowClockGate, updating on the same edge as Slow.
REQ-028 SLOW_CLOCKGATE_EN undefined: ClockGate is tied 0 and no SlowClockGate logic is synthesized; all other behaviour is identical.

Verification
REQ-029 Reset, then VIACS=1, SlowVIA=1, BACT=1 for 5 cycles, SlowTimeout=3 -> Slow=1 one cycle after BACT rises; Slow falls 4*64+1 cycles after BACT falls, within one cycle.
REQ-030 SCCCS=1, SlowSCC=0, BACT=1 -> Slow stays 0 and state stays IDLE.
REQ-031 SlowTimeout=0, IWM access -> HOLD lasts exactly 1 cycle, then IDLE.
REQ-032 SlowTimeout=2; new VIA access 70 cycles into HOLD -> state returns to ACTIVE; after the new BACT falls, the full 3*64+1 cycle hold repeats.
REQ-033 nPOR pulsed low mid-HOLD -> Slow=0 immediately (asynchronous); after release, IDLE and Slow stays 0.
REQ-034 With SLOW_CLOCKGATE_EN and SlowClockGate=1 -> ClockGate tracks Slow cycle-exactly; without the macro -> ClockGate=0 throughout.
